bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Reads a contiguous block of words from port 1 of the true dual-port BRAM, starting at address 0.
- Presents the words in address order on a valid/ready stream interface.
- Is the read-side counterpart of the BRAM write/read controller on port 0: once the controller has filled memory, this block drains it to a downstream consumer with full backpressure.
- BRAM read latency is 1 cycle: q1 is valid the cycle after ce1=1, we1=0.

Parameters:
- DWIDTH, 16, data word width.
- AWIDTH, 7, address width.
- MEM_SIZE, 128, memory depth in words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_num_cnt  in  AWIDTH  number of words to read (N); latched when i_run is accepted.
- o_idle  out  1  high in IDLE.
- o_read  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.
- addr1  out  AWIDTH  BRAM port-1 address.
- ce1  out  1  BRAM port-1 chip enable.
- we1  out  1  tied 0.
- d1  out  DWIDTH  tied 0.
- q1  in  DWIDTH  BRAM port-1 read data (1-cycle latency).
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DWIDTH  stream data.

Behaviour:
- Reset (async, any state): FSM returns to IDLE; issue/accept counters = 0; 2-entry output buffer flushed; in-flight flag cleared.
  - Output values during reset: o_idle=1, o_read=0, o_done=0, ce1=0, addr1=0, m_valid=0, m_data=0.
  - A read in flight at reset is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when i_run=1 and i_num_cnt!=0; N is latched.
  - IDLE -> DONE when i_run=1 and i_num_cnt==0.
  - RUN -> DONE on the cycle the N-th word handshakes (m_valid and m_ready).
  - DONE -> IDLE unconditionally after 1 cycle.
- i_run is ignored in RUN and DONE. A change on i_num_cnt after latch has no effect.
- Issue counter (issued, AWIDTH+1 bits):
  - addr1 = issued[AWIDTH-1:0].
  - Increments on each cycle with ce1=1.
- Issue rule (combinational): ce1 = RUN and issued<N and (occ + inflight - pop) <= 1.
  - occ is the buffer occupancy (0..2).
  - inflight = ce1 registered from the previous cycle.
  - pop = m_valid and m_ready.
- No read is issued beyond address N-1. Addresses never wrap; N is at most 2^AWIDTH-1.
- Data capture: in the cycle inflight=1, q1 is written into the buffer tail. The credit rule guarantees the buffer never overflows.
- Stream:
  - m_valid = (occ != 0); m_data = buffer head.
  - Data is held stable while m_valid=1 and m_ready=0.
  - Push and pop in the same cycle are both honoured, and occ is unchanged.
- Latency: with i_run sampled at edge E0:
  - ce1=1 with addr1=0 in cycle E0..E1.
  - Data is captured at E2.
  - m_valid rises after E2, i.e. 3 cycles after i_run.
- Throughput: 1 word/cycle while m_ready stays 1.
- Ordering: m_data sequence = mem[0], mem[1], …, mem[N-1]. No duplicates or drops under any m_ready pattern.
- Accept counter: counts pops. RUN ends only after N pops, not after N issues.
- N=0: no BRAM access; m_valid stays 0; o_done pulses 1 cycle after i_run.

Test Plan:
- Preload mem[k]=16'hA000+k, N=100, m_ready=1 -> 100 words A000..A063 in order; m_valid continuous from 3 cycles after i_run; o_done 1 cycle after the last handshake; o_idle the cycle after.
- Same preload, N=100, m_ready random 50% -> identical data sequence; m_data stable while stalled; ce1 never high when occ+inflight-pop>1; ce1 count = 100.
- N=1, m_ready=0 for 10 cycles then 1 -> single ce1 at addr 0; m_valid held 10+ cycles with A000; o_done the cycle after the handshake.
- N=0 -> no ce1 asserted; m_valid stays 0; o_done pulses 1 cycle after i_run; back to IDLE.
- N=127, m_ready=1 -> last address 7'd126; no access to 127; exactly 127 words.
- Assert reset mid-RUN after 20 words with a read in flight -> all outputs at reset values immediately; new i_run N=5 -> A000..A004 with no stale data.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Drains words 0..N-1 from BRAM port 1 onto a valid/ready stream.
// A 2-entry skid buffer plus read credit tracking gives full backpressure at 1 word/cycle.
module bram_stream_reader #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_read,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr1,
    output logic              ce1,
    output logic              we1,
    output logic [DWIDTH-1:0] d1,
    input  logic [DWIDTH-1:0] q1,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [AWIDTH-1:0] n_q;
    logic [AWIDTH:0]   issued_q;
    logic [AWIDTH:0]   accepted_q;
    logic              inflight_q;
    logic [DWIDTH-1:0] buf0_q;
    logic [DWIDTH-1:0] buf1_q;
    logic [1:0]        occ_q;

    logic              pop;
    logic              push;
    logic [2:0]        credit;
    logic [AWIDTH:0]   n_ext;

    assign n_ext   = {1'b0, n_q};
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q;

    // Words already buffered or on their way, after this cycle's pop leaves.
    assign credit  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign ce1     = (state_q == RUN) && (issued_q < n_ext) && (credit <= 3'd1)
                     && (int'(issued_q) < MEM_SIZE);
    assign addr1   = issued_q[AWIDTH-1:0];
    assign we1     = 1'b0;
    assign d1      = '0;

    assign o_idle  = (state_q == IDLE);
    assign o_read  = (state_q == RUN);
    assign o_done  = (state_q == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            occ_q      <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_run) begin
                        n_q        <= i_num_cnt;
                        issued_q   <= '0;
                        accepted_q <= '0;
                        state_q    <= (i_num_cnt != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (ce1) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (pop) begin
                        accepted_q <= accepted_q + 1'b1;
                        if (accepted_q + 1'b1 == n_ext) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            inflight_q <= ce1;

            // Head is always buf0; a pop shifts buf1 down before the push lands.
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_q <= q1;
                    end else begin
                        buf1_q <= q1;
                    end
                    occ_q <= occ_q + 1'b1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 1'b1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= q1;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= q1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural BRAM, expected stream taken straight from memory
// contents, read credit checked as (reads issued - words popped).
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_run;
    logic [6:0]  i_num_cnt;
    logic        o_idle, o_read, o_done;
    logic [6:0]  addr1;
    logic        ce1, we1;
    logic [15:0] d1;
    logic [15:0] q1 = '0;
    logic        m_valid, m_ready;
    logic [15:0] m_data;

    logic [15:0] mem [0:127];

    int total = 0;
    int bad   = 0;

    int r_words, r_ce, r_max_addr, r_done_c, r_last_hs, r_first_valid, r_first_ce, r_valid_cycles;

    bram_stream_reader #(.DWIDTH(16), .AWIDTH(7), .MEM_SIZE(128)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_read(o_read), .o_done(o_done),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce1 && !we1) q1 <= mem[addr1];
    end

    // mode 0: always ready, 1: random ready, 2: not ready for the first 12 cycles
    task automatic run_case(input int n, input int mode, input string tag);
        int c, iss, pops, prev_stall;
        bit pop, done_seen;
        logic [15:0] prev_data;
        c = 0; iss = 0; pops = 0; prev_stall = 0; done_seen = 0; prev_data = '0;
        r_max_addr = -1; r_done_c = -1; r_last_hs = -1; r_first_valid = -1;
        r_first_ce = -1; r_valid_cycles = 0;
        @(posedge clk); #1;
        i_run = 1'b1;
        i_num_cnt = 7'(n);
        @(posedge clk); #1;
        while (!done_seen && c < 3000) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (c >= 12);
            endcase
            i_run = 1'($urandom_range(0, 1));
            i_num_cnt = 7'($urandom);
            @(negedge clk);
            pop = m_valid && m_ready;
            if (ce1) begin
                total++;
                if (addr1 !== 7'(iss) || iss >= n) begin
                    bad++;
                    $display("FAIL %s addr: got %0d ce_index %0d n %0d", tag, addr1, iss, n);
                end
                total++;
                if (iss - pops - int'(pop) > 1) begin
                    bad++;
                    $display("FAIL %s credit: outstanding %0d pop %0d, need <=1 after pop", tag, iss - pops, pop);
                end
                iss++;
                r_max_addr = int'(addr1);
                if (r_first_ce < 0) r_first_ce = c;
            end
            if (m_valid) begin
                r_valid_cycles++;
                if (r_first_valid < 0) r_first_valid = c;
            end
            if (prev_stall != 0) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    bad++;
                    $display("FAIL %s stall_hold: valid %b data %h, need 1 %h", tag, m_valid, m_data, prev_data);
                end
            end
            if (mode == 0 && n > 0 && c >= 2 && pops < n) begin
                total++;
                if (m_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s bubble at cycle %0d: valid %b need 1", tag, c, m_valid);
                end
            end
            if (pop) begin
                total++;
                if (pops >= n || m_data !== mem[pops]) begin
                    bad++;
                    $display("FAIL %s data[%0d]: got %h need %h", tag, pops, m_data, 16'hA000 + 16'(pops));
                end
                pops++;
                r_last_hs = c;
            end
            total++;
            if (o_done === 1'b1) begin
                if (o_read !== 1'b0 || o_idle !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_flags: read %b idle %b need 0 0", tag, o_read, o_idle);
                end
                done_seen = 1;
                r_done_c = c;
            end else if (o_read !== (n > 0) || o_idle !== 1'b0) begin
                bad++;
                $display("FAIL %s run_flags: read %b idle %b need %b 0", tag, o_read, o_idle, n > 0);
            end
            prev_stall = (m_valid && !m_ready) ? 1 : 0;
            prev_data = m_data;
            @(posedge clk); #1;
            c++;
        end
        i_run = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no o_done within %0d cycles", tag, c);
        end
        @(negedge clk);
        total++;
        if (o_idle !== 1'b1 || o_done !== 1'b0 || m_valid !== 1'b0 || ce1 !== 1'b0) begin
            bad++;
            $display("FAIL %s post_done: idle %b done %b valid %b ce1 %b need 1 0 0 0", tag, o_idle, o_done, m_valid, ce1);
        end
        r_words = pops;
        r_ce = iss;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; m_ready = 1'b0;
        #1;
        total++;
        if ({o_idle, o_read, o_done, ce1, addr1, m_valid, m_data} !== {4'b1000, 7'd0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset_values: idle %b read %b done %b ce1 %b addr %0d valid %b data %h", o_idle, o_read, o_done, ce1, addr1, m_valid, m_data);
        end
        total++;
        if (we1 !== 1'b0 || d1 !== 16'd0) begin
            bad++;
            $display("FAIL write_port_tied: we1 %b d1 %h need 0 0000", we1, d1);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_full_rate();
        run_case(100, 0, "full_rate");
        total++;
        if (r_words != 100 || r_ce != 100 || r_max_addr != 99) begin
            bad++;
            $display("FAIL full_rate counts: words %0d reads %0d last_addr %0d need 100 100 99", r_words, r_ce, r_max_addr);
        end
        total++;
        if (r_first_ce != 0 || r_first_valid != 2) begin
            bad++;
            $display("FAIL full_rate latency: first_ce %0d first_valid %0d need 0 2", r_first_ce, r_first_valid);
        end
        total++;
        if (r_done_c != r_last_hs + 1) begin
            bad++;
            $display("FAIL full_rate done_timing: done %0d last_hs %0d need last_hs+1", r_done_c, r_last_hs);
        end
    endtask

    task automatic test_backpressure();
        run_case(100, 1, "backpressure");
        total++;
        if (r_words != 100 || r_ce != 100) begin
            bad++;
            $display("FAIL backpressure counts: words %0d reads %0d need 100 100", r_words, r_ce);
        end
        total++;
        if (r_done_c != r_last_hs + 1) begin
            bad++;
            $display("FAIL backpressure done_timing: done %0d last_hs %0d need last_hs+1", r_done_c, r_last_hs);
        end
    endtask

    task automatic test_single_stall();
        run_case(1, 2, "single_stall");
        total++;
        if (r_ce != 1 || r_max_addr != 0 || r_words != 1) begin
            bad++;
            $display("FAIL single_stall counts: reads %0d addr %0d words %0d need 1 0 1", r_ce, r_max_addr, r_words);
        end
        total++;
        if (r_valid_cycles < 10 || r_last_hs != 12 || r_done_c != 13) begin
            bad++;
            $display("FAIL single_stall timing: valid_cycles %0d hs %0d done %0d need >=10 12 13", r_valid_cycles, r_last_hs, r_done_c);
        end
    endtask

    task automatic test_zero();
        run_case(0, 0, "zero");
        total++;
        if (r_ce != 0 || r_first_valid != -1 || r_done_c != 0) begin
            bad++;
            $display("FAIL zero: reads %0d first_valid %0d done %0d need 0 -1 0", r_ce, r_first_valid, r_done_c);
        end
    endtask

    task automatic test_max_count();
        run_case(127, 0, "max_count");
        total++;
        if (r_words != 127 || r_ce != 127 || r_max_addr != 126) begin
            bad++;
            $display("FAIL max_count: words %0d reads %0d last_addr %0d need 127 127 126", r_words, r_ce, r_max_addr);
        end
    endtask

    task automatic test_reset_midrun();
        int pops, c;
        bit issued_now;
        pops = 0; c = 0; issued_now = 0;
        @(posedge clk); #1;
        i_run = 1'b1; i_num_cnt = 7'd100; m_ready = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        while (pops < 20 && c < 200) begin
            @(negedge clk);
            if (m_valid && m_ready) pops++;
            issued_now = ce1;
            @(posedge clk); #1;
            c++;
        end
        total++;
        if (pops != 20 || issued_now != 1'b1) begin
            bad++;
            $display("FAIL midrun_setup: pops %0d read_in_flight %b need 20 1", pops, issued_now);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({o_idle, o_read, o_done, ce1, addr1, m_valid, m_data} !== {4'b1000, 7'd0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL midrun_reset_values: idle %b read %b done %b ce1 %b addr %0d valid %b data %h", o_idle, o_read, o_done, ce1, addr1, m_valid, m_data);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_case(5, 0, "after_reset");
        total++;
        if (r_words != 5 || r_ce != 5 || r_first_valid != 2) begin
            bad++;
            $display("FAIL after_reset: words %0d reads %0d first_valid %0d need 5 5 2", r_words, r_ce, r_first_valid);
        end
    endtask

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 16'hA000 + 16'(k);
        test_reset();
        test_full_rate();
        test_backpressure();
        test_single_stall();
        test_zero();
        test_max_count();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
